// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of one single-ported memory with fixed read latency.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 always win ties (port 1 may starve).
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake: mN_req is held high until the one-cycle mN_gnt, which marks the cycle the
  // command is on the memory bus; mN_rvalid is a one-cycle pulse with no backpressure.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic          cmd_we, cmd_we_nxt;
  logic [AW-1:0] cmd_addr, cmd_addr_nxt;
  logic [DW-1:0] cmd_wdata, cmd_wdata_nxt;
  logic [2:0]    lat_cnt, lat_cnt_nxt;
  logic          winner;
  logic          issue;
  logic          rd_done;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign winner = m1_req & ~m0_req;
`else
  assign winner = (m0_req & m1_req) ? ~last : m1_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      lat_cnt   <= 3'd0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      cmd_we    <= cmd_we_nxt;
      cmd_addr  <= cmd_addr_nxt;
      cmd_wdata <= cmd_wdata_nxt;
      lat_cnt   <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    cmd_we_nxt    = cmd_we;
    cmd_addr_nxt  = cmd_addr;
    cmd_wdata_nxt = cmd_wdata;
    lat_cnt_nxt   = lat_cnt;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt     = ISSUE;
          owner_nxt     = winner;
          last_nxt      = winner;
          cmd_we_nxt    = winner ? m1_we    : m0_we;
          cmd_addr_nxt  = winner ? m1_addr  : m0_addr;
          cmd_wdata_nxt = winner ? m1_wdata : m0_wdata;
        end
      end
      ISSUE: begin
        if (cmd_we) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = RDWAIT;
          lat_cnt_nxt = LAT_INIT;
        end
      end
      RDWAIT: begin
        if (lat_cnt == 3'd0) state_nxt = IDLE;
        else                 lat_cnt_nxt = lat_cnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign issue   = (state == ISSUE);
  assign rd_done = (state == RDWAIT) && (lat_cnt == 3'd0);

  // Memory command bus is zeroed outside the issue cycle so idle cycles are unambiguous.
  assign mem_en    = issue;
  assign mem_we    = issue & cmd_we;
  assign mem_addr  = issue ? cmd_addr  : '0;
  assign mem_wdata = issue ? cmd_wdata : '0;

  assign m0_gnt    = issue & ~owner;
  assign m1_gnt    = issue & owner;
  assign m0_rvalid = rd_done & ~owner;
  assign m1_rvalid = rd_done & owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
